// File: rtl/fantasy_pkg.sv
// rtl/fantasy_pkg.sv - operating-mode encodings and mode family helpers
package fantasy_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_DIRECT    = 3'd0;
    localparam logic [MODE_W-1:0] MODE_INV       = 3'd1;
    localparam logic [MODE_W-1:0] MODE_BLK_DARK  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_BLK_LIGHT = 3'd3;

    function automatic logic is_blk(input logic [MODE_W-1:0] mode);
        is_blk = (mode == MODE_BLK_DARK) || (mode == MODE_BLK_LIGHT);
    endfunction

    function automatic logic is_inv(input logic [MODE_W-1:0] mode);
        is_inv = (mode == MODE_INV) || (mode == MODE_BLK_LIGHT);
    endfunction

    // Encodings 4..7 decode as DIRECT, so they toggle exactly like DIRECT.
    function automatic logic [MODE_W-1:0] toggle_blk(input logic [MODE_W-1:0] mode);
        case (mode)
            MODE_INV:       toggle_blk = MODE_BLK_LIGHT;
            MODE_BLK_DARK:  toggle_blk = MODE_DIRECT;
            MODE_BLK_LIGHT: toggle_blk = MODE_INV;
            default:        toggle_blk = MODE_BLK_DARK;
        endcase
    endfunction

    function automatic logic [MODE_W-1:0] toggle_inv(input logic [MODE_W-1:0] mode);
        case (mode)
            MODE_INV:       toggle_inv = MODE_DIRECT;
            MODE_BLK_DARK:  toggle_inv = MODE_BLK_LIGHT;
            MODE_BLK_LIGHT: toggle_inv = MODE_BLK_DARK;
            default:        toggle_inv = MODE_INV;
        endcase
    endfunction

endpackage

// File: rtl/frame_px_count.sv
// rtl/frame_px_count.sv - saturating per-frame pixel counter with sampled statistic
module frame_px_count #(
    parameter int CW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] stat
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            stat_q <= '0;
        end else if (clr) begin
            stat_q <= cnt_q;
            cnt_q  <= en ? CNT_ONE : '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q  <= cnt_q + CNT_ONE;
        end
    end

    // Forward the count in the sampling cycle so the caller can decide on it immediately.
    assign stat = clr ? cnt_q : stat_q;

endmodule

// File: rtl/fantasy_mode_ctrl.sv
// rtl/fantasy_mode_ctrl.sv - frame-synchronous mode controller with auto block-invert
module fantasy_mode_ctrl
    import fantasy_pkg::*;
#(
    parameter int CW    = 22,
    parameter int TH_HI = 1036800,
    parameter int TH_LO = 622080,
    parameter int DWELL = 4
) (
    input  logic              vout_clk_i,
    input  logic              rst_n,
    input  logic [3:0]        button_press_i,
    input  logic [3:0]        button_hold_i,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic              blk_x_i,
    output logic [MODE_W-1:0] mode_o,
    output logic              px_inv_o,
    output logic [3:0]        led_o
);

    localparam logic [CW-1:0] TH_HI_W = CW'(TH_HI);
    localparam logic [CW-1:0] TH_LO_W = CW'(TH_LO);
    localparam logic [3:0]    DWELL_W = 4'(DWELL);

    logic              vs_q;
    logic              fe;
    logic [MODE_W-1:0] pending, pending_nx, commit_mode, mode_nx, eff_mode;
    logic              auto_en, auto_nx;
    logic [3:0]        dwell, dwell_nx;
    logic [CW-1:0]     stat;
    logic              press_blk, press_inv, press_auto;
    logic              want_blk, auto_flip;
    logic              unused_buttons;

    assign fe             = vs_i & ~vs_q;
    assign unused_buttons = &{1'b0, button_press_i[3], button_press_i[0], button_hold_i[2:0]};

    frame_px_count #(.CW(CW)) u_px_count (
        .clk   (vout_clk_i),
        .rst_n (rst_n),
        .en    (de_i & blk_x_i),
        .clr   (fe),
        .stat  (stat)
    );

    always_comb begin
        press_blk  = button_press_i[1] & ~button_press_i[2];
        press_inv  = button_press_i[2] & ~button_press_i[1];
        press_auto = button_press_i[1] &  button_press_i[2];

        want_blk = is_blk(pending);
        if (stat > TH_HI_W) begin
            want_blk = 1'b1;
        end else if (stat < TH_LO_W) begin
            want_blk = 1'b0;
        end

        // Manual blk toggles and auto-enable toggles suppress the auto decision.
        auto_flip = 1'b0;
        dwell_nx  = dwell;
        if (press_blk || press_auto) begin
            dwell_nx = '0;
        end else if (fe && auto_en) begin
            if (want_blk != is_blk(pending)) begin
                if ((dwell + 4'd1) == DWELL_W) begin
                    auto_flip = 1'b1;
                    dwell_nx  = '0;
                end else begin
                    dwell_nx  = dwell + 4'd1;
                end
            end else begin
                dwell_nx = '0;
            end
        end

        // Manual edits land in pending after this edge; only the auto flip reaches the commit.
        commit_mode = auto_flip ? toggle_blk(pending) : pending;
        pending_nx  = commit_mode;
        if (press_blk) begin
            pending_nx = toggle_blk(pending);
        end else if (press_inv) begin
            pending_nx = toggle_inv(commit_mode);
        end

        auto_nx = auto_en;
        if (press_blk) begin
            auto_nx = 1'b0;
        end else if (press_auto) begin
            auto_nx = ~auto_en;
        end

        mode_nx = fe ? commit_mode : mode_o;
    end

    always_ff @(posedge vout_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= 1'b0;
            pending <= MODE_BLK_DARK;
            mode_o  <= MODE_BLK_DARK;
            auto_en <= 1'b0;
            dwell   <= '0;
            led_o   <= 4'b0001;
        end else begin
            vs_q    <= vs_i;
            pending <= pending_nx;
            mode_o  <= mode_nx;
            auto_en <= auto_nx;
            dwell   <= dwell_nx;
            led_o   <= {is_inv(mode_nx), pending_nx != mode_nx, auto_nx, is_blk(mode_nx)};
        end
    end

    assign eff_mode = button_hold_i[3] ? MODE_DIRECT : mode_o;

    always_comb begin
        case (eff_mode)
            MODE_INV:       px_inv_o = 1'b1;
            MODE_BLK_DARK:  px_inv_o = blk_x_i;
            MODE_BLK_LIGHT: px_inv_o = ~blk_x_i;
            default:        px_inv_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fantasy_mode_ctrl.sv
// tb/tb_fantasy_mode_ctrl.sv - directed self-checking bench for fantasy_mode_ctrl
module tb_fantasy_mode_ctrl;

    logic       vout_clk_i     = 1'b0;
    logic       rst_n          = 1'b0;
    logic [3:0] button_press_i = 4'b0;
    logic [3:0] button_hold_i  = 4'b0;
    logic       vs_i           = 1'b0;
    logic       de_i           = 1'b0;
    logic       blk_x_i        = 1'b0;
    logic [2:0] mode_o;
    logic       px_inv_o;
    logic [3:0] led_o;

    int tests = 0;
    int fails = 0;

    fantasy_mode_ctrl #(.CW(4), .TH_HI(8), .TH_LO(4), .DWELL(2)) dut (
        .vout_clk_i     (vout_clk_i),
        .rst_n          (rst_n),
        .button_press_i (button_press_i),
        .button_hold_i  (button_hold_i),
        .vs_i           (vs_i),
        .de_i           (de_i),
        .blk_x_i        (blk_x_i),
        .mode_o         (mode_o),
        .px_inv_o       (px_inv_o),
        .led_o          (led_o)
    );

    always #5 vout_clk_i = ~vout_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vout_clk_i);
        #1;
    endtask

    task automatic frame_edge();
        vs_i = 1'b1;
        step();
        vs_i = 1'b0;
        step();
    endtask

    task automatic pixels(input int n);
        de_i    = 1'b1;
        blk_x_i = 1'b1;
        repeat (n) step();
        de_i    = 1'b0;
        blk_x_i = 1'b0;
    endtask

    task automatic frame(input int n);
        pixels(n);
        frame_edge();
    endtask

    task automatic press(input logic [3:0] p);
        button_press_i = p;
        step();
        button_press_i = 4'b0;
    endtask

    initial begin
        repeat (2) step();
        check("rst_mode", mode_o, 3'd2);
        check("rst_led", led_o, 4'b0001);
        check("rst_pending", dut.pending, 3'd2);
        blk_x_i = 1'b1; #1;
        check("rst_pxinv_x1", px_inv_o, 1'b1);
        blk_x_i = 1'b0; #1;
        check("rst_pxinv_x0", px_inv_o, 1'b0);
        rst_n = 1'b1;
        step();

        frame_edge();
        check("fe1_mode", mode_o, 3'd2);
        check("fe1_led", led_o, 4'b0001);

        pixels(3);
        press(4'b0100);
        check("inv_pending", dut.pending, 3'd3);
        check("inv_mode_hold", mode_o, 3'd2);
        check("inv_led", led_o, 4'b0101);
        frame_edge();
        check("inv_commit", mode_o, 3'd3);
        check("inv_led_commit", led_o, 4'b1001);
        blk_x_i = 1'b1; #1;
        check("light_pxinv_x1", px_inv_o, 1'b0);
        blk_x_i = 1'b0; #1;
        check("light_pxinv_x0", px_inv_o, 1'b1);

        button_hold_i = 4'b1000; #1;
        check("bypass_pxinv", px_inv_o, 1'b0);
        step();
        check("bypass_hold_pxinv", px_inv_o, 1'b0);
        check("bypass_mode", mode_o, 3'd3);
        button_hold_i = 4'b0000; #1;
        check("bypass_release", px_inv_o, 1'b1);

        pixels(20);
        check("sat_cnt", dut.u_px_count.cnt_q, 4'd15);
        vs_i = 1'b1; de_i = 1'b1; blk_x_i = 1'b1;
        step();
        vs_i = 1'b0; de_i = 1'b0; blk_x_i = 1'b0;
        check("sat_stat", dut.u_px_count.stat_q, 4'd15);
        check("fe_pixel_cnt", dut.u_px_count.cnt_q, 4'd1);
        step();
        check("sat_mode", mode_o, 3'd3);

        press(4'b0100);
        press(4'b0010);
        check("to_direct_pending", dut.pending, 3'd0);
        frame_edge();
        check("direct_commit", mode_o, 3'd0);
        check("direct_led", led_o, 4'b0000);

        press(4'b0110);
        check("auto_on_led", led_o, 4'b0010);
        check("auto_on_pending", dut.pending, 3'd0);

        frame(10);
        check("auto_a_pending", dut.pending, 3'd0);
        check("auto_a_mode", mode_o, 3'd0);
        frame(10);
        check("auto_b_mode", mode_o, 3'd2);
        check("auto_b_led", led_o, 4'b0011);
        frame(6);
        check("auto_c_mode", mode_o, 3'd2);
        frame(8);
        check("auto_d_th_hi_edge", mode_o, 3'd2);
        frame(3);
        check("auto_e_mode", mode_o, 3'd2);
        frame(4);
        check("auto_f_th_lo_edge", mode_o, 3'd2);
        frame(3);
        check("auto_g_dwell_reset", mode_o, 3'd2);
        frame(3);
        check("auto_h_mode", mode_o, 3'd0);
        check("auto_h_led", led_o, 4'b0010);

        frame(10);
        pixels(10);
        vs_i = 1'b1; button_press_i = 4'b0010;
        step();
        vs_i = 1'b0; button_press_i = 4'b0000;
        check("win_mode", mode_o, 3'd0);
        check("win_pending", dut.pending, 3'd2);
        check("win_led", led_o, 4'b0100);
        step();
        frame_edge();
        check("win_commit", mode_o, 3'd2);
        check("win_commit_led", led_o, 4'b0001);

        pixels(5);
        press(4'b0100);
        check("pre_rst_pending", dut.pending, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mode", mode_o, 3'd2);
        check("arst_pending", dut.pending, 3'd2);
        check("arst_led", led_o, 4'b0001);
        check("arst_cnt", dut.u_px_count.cnt_q, 4'd0);
        step();
        rst_n = 1'b1;
        step();
        frame_edge();
        check("arst_fe_mode", mode_o, 3'd2);
        check("arst_fe_led", led_o, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
